// File: rtl/zone_max_stats.sv
// Tiles a raster stream of per-pixel max values into zones and emits one max per zone in raster zone order.
// Optional build macro ZONE_MEAN_EN adds a zone_mean output backed by a parallel sum buffer.
module zone_max_stats #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 32,
  parameter int unsigned ZONE_W     = 16,
  parameter int unsigned ZONE_H     = 8,
  localparam int unsigned NZX  = IMG_W / ZONE_W,
  localparam int unsigned NZY  = IMG_H / ZONE_H,
  localparam int unsigned ZX_W = (NZX > 1) ? $clog2(NZX) : 1,
  localparam int unsigned ZY_W = (NZY > 1) ? $clog2(NZY) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  zone_valid,
  output logic [DATA_WIDTH-1:0] zone_max,
  output logic [ZX_W-1:0]       zone_x,
  output logic [ZY_W-1:0]       zone_y,
  output logic                  frame_done,
`ifdef ZONE_MEAN_EN
  output logic [DATA_WIDTH-1:0] zone_mean,
`endif
  output logic                  sof_err
);

  localparam int unsigned PX_W = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
  localparam int unsigned LN_W = (ZONE_H > 1) ? $clog2(ZONE_H) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [PX_W-1:0]       px_q, px_d, cur_px;
  logic [ZX_W-1:0]       col_q, col_d, cur_col;
  logic [LN_W-1:0]       line_q, line_d, cur_line;
  logic [ZY_W-1:0]       row_q, row_d, cur_row;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, merged_max;
  logic [DATA_WIDTH-1:0] max_buf [NZX];
  logic                  start, accept, first_pix;
  logic                  seg_last, col_last, line_last, row_last, frame_last;
  logic                  buf_we, zone_valid_d, frame_done_d, sof_err_d;

`ifdef ZONE_MEAN_EN
  localparam int unsigned MEAN_SH = $clog2(ZONE_W * ZONE_H);
  localparam int unsigned SUM_W   = DATA_WIDTH + MEAN_SH;
  logic [SUM_W-1:0] sum_q, sum_d, merged_sum;
  logic [SUM_W-1:0] sum_buf [NZX];
`endif

  // An in_sof pixel always restarts the raster at (0,0), whatever the counters say.
  always_comb begin
    start      = in_valid & in_sof;
    accept     = in_valid & (start | (state_q == RUN));
    first_pix  = (px_q == '0) && (col_q == '0) && (line_q == '0) && (row_q == '0);
    cur_px     = start ? '0 : px_q;
    cur_col    = start ? '0 : col_q;
    cur_line   = start ? '0 : line_q;
    cur_row    = start ? '0 : row_q;
    seg_last   = (cur_px == PX_W'(ZONE_W - 1));
    col_last   = (cur_col == ZX_W'(NZX - 1));
    line_last  = (cur_line == LN_W'(ZONE_H - 1));
    row_last   = (cur_row == ZY_W'(NZY - 1));
    frame_last = seg_last & col_last & line_last & row_last;
    acc_d      = ((cur_px == '0) || (in_data > acc_q)) ? in_data : acc_q;
    merged_max = ((cur_line == '0) || (acc_d >= max_buf[cur_col])) ? acc_d : max_buf[cur_col];
`ifdef ZONE_MEAN_EN
    sum_d      = (cur_px == '0) ? SUM_W'(in_data) : sum_q + SUM_W'(in_data);
    merged_sum = (cur_line == '0) ? sum_d : sum_d + sum_buf[cur_col];
`endif
  end

  // Next-state, counter advance and output strobes.
  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    col_d        = col_q;
    line_d       = line_q;
    row_d        = row_q;
    buf_we       = 1'b0;
    zone_valid_d = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = start & (state_q == RUN) & ~first_pix;
    if (accept) begin
      px_d   = seg_last ? '0 : cur_px + PX_W'(1);
      col_d  = cur_col;
      line_d = cur_line;
      row_d  = cur_row;
      if (seg_last) col_d = col_last ? '0 : cur_col + ZX_W'(1);
      if (seg_last && col_last) line_d = line_last ? '0 : cur_line + LN_W'(1);
      if (seg_last && col_last && line_last) row_d = row_last ? '0 : cur_row + ZY_W'(1);
      state_d      = frame_last ? IDLE : RUN;
      buf_we       = seg_last & ~line_last;
      zone_valid_d = seg_last & line_last;
      frame_done_d = frame_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      px_q       <= '0;
      col_q      <= '0;
      line_q     <= '0;
      row_q      <= '0;
      acc_q      <= '0;
      zone_valid <= 1'b0;
      zone_max   <= '0;
      zone_x     <= '0;
      zone_y     <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
`ifdef ZONE_MEAN_EN
      sum_q      <= '0;
      zone_mean  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      col_q      <= col_d;
      line_q     <= line_d;
      row_q      <= row_d;
      zone_valid <= zone_valid_d;
      frame_done <= frame_done_d;
      sof_err    <= sof_err_d;
      if (accept) acc_q <= acc_d;
      if (zone_valid_d) begin
        zone_max <= merged_max;
        zone_x   <= cur_col;
        zone_y   <= cur_row;
      end
`ifdef ZONE_MEAN_EN
      if (accept) sum_q <= sum_d;
      if (zone_valid_d) zone_mean <= DATA_WIDTH'(merged_sum >> MEAN_SH);
`endif
    end
  end

  // Row buffer of partial zone results; always written before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      max_buf[cur_col] <= merged_max;
`ifdef ZONE_MEAN_EN
      sum_buf[cur_col] <= merged_sum;
`endif
    end
  end

endmodule

// File: tb/tb_zone_max_stats.sv
// Randomized/directed bench for zone_max_stats against a frame-image reference model.
module tb_zone_max_stats;

  localparam int unsigned DW     = 8;
  localparam int unsigned IMG_W  = 64;
  localparam int unsigned IMG_H  = 32;
  localparam int unsigned ZONE_W = 16;
  localparam int unsigned ZONE_H = 8;
  localparam int unsigned NZX    = IMG_W / ZONE_W;
  localparam int unsigned NZY    = IMG_H / ZONE_H;
  localparam int unsigned NZ     = NZX * NZY;
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned MSH    = $clog2(ZONE_W * ZONE_H);

  logic          clk = 1'b0;
  logic          rst, in_valid, in_sof;
  logic [DW-1:0] in_data;
  logic          zone_valid, frame_done, sof_err;
  logic [DW-1:0] zone_max;
  logic [1:0]    zone_x, zone_y;
`ifdef ZONE_MEAN_EN
  logic [DW-1:0] zone_mean;
`endif

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_done = 0, n_err = 0;
  bit in_frame = 1'b0;
  int p = 0;
  logic [DW-1:0] img [IMG_H][IMG_W];

  zone_max_stats #(.DATA_WIDTH(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .ZONE_W(ZONE_W), .ZONE_H(ZONE_H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .zone_valid(zone_valid), .zone_max(zone_max), .zone_x(zone_x), .zone_y(zone_y),
    .frame_done(frame_done),
`ifdef ZONE_MEAN_EN
    .zone_mean(zone_mean),
`endif
    .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the reference frame, drive inputs, then check registered outputs.
  task automatic step(input bit r, input bit v, input bit s, input logic [DW-1:0] d);
    bit e_valid = 0, e_done = 0, e_err = 0;
    int x, y, ex = 0, ey = 0, emax = 0, esum = 0;
    if (r) in_frame = 0;
    else begin
      if (v && s) begin
        if (in_frame && p != 0) e_err = 1;
        in_frame = 1;
        p = 0;
      end
      if (v && in_frame) begin
        x = p % IMG_W;
        y = p / IMG_W;
        img[y][x] = d;
        if ((x % ZONE_W == ZONE_W - 1) && (y % ZONE_H == ZONE_H - 1)) begin
          e_valid = 1;
          ex = x / ZONE_W;
          ey = y / ZONE_H;
          for (int yy = ey * ZONE_H; yy < (ey + 1) * ZONE_H; yy++)
            for (int xx = ex * ZONE_W; xx < (ex + 1) * ZONE_W; xx++) begin
              if (int'(img[yy][xx]) > emax) emax = int'(img[yy][xx]);
              esum += int'(img[yy][xx]);
            end
        end
        if (p == NPIX - 1) begin
          e_done = 1;
          in_frame = 0;
        end
        p++;
      end
    end
    rst = r; in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    #1;
    if (zone_valid) n_valid++;
    if (frame_done) n_done++;
    if (sof_err) n_err++;
    chk("zone_valid", 32'(zone_valid), 32'(e_valid));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("sof_err", 32'(sof_err), 32'(e_err));
    if (r) begin
      chk("rst_zone_max", 32'(zone_max), 0);
      chk("rst_zone_x", 32'(zone_x), 0);
      chk("rst_zone_y", 32'(zone_y), 0);
`ifdef ZONE_MEAN_EN
      chk("rst_zone_mean", 32'(zone_mean), 0);
`endif
    end else if (e_valid) begin
      chk("zone_max", 32'(zone_max), 32'(emax));
      chk("zone_x", 32'(zone_x), 32'(ex));
      chk("zone_y", 32'(zone_y), 32'(ey));
`ifdef ZONE_MEAN_EN
      chk("zone_mean", 32'(zone_mean), 32'(esum >> MSH));
`endif
    end
  endtask

  // kind: 0 const 0x40, 1 zeros with 0xFF spike at (sx,sy), 2 ramp, 3 random.
  task automatic send_frame(input int kind, input int duty, input int npix, input int sx, input int sy);
    int x, y;
    logic [DW-1:0] d;
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(99) >= duty)
        step(0, 0, 1'($urandom_range(1)), DW'($urandom));
      x = i % IMG_W;
      y = i / IMG_W;
      case (kind)
        0:       d = 8'h40;
        1:       d = (x == sx && y == sy) ? 8'hFF : 8'h00;
        2:       d = DW'(x + y);
        default: d = DW'($urandom);
      endcase
      step(0, 1, i == 0, d);
    end
  endtask

  int v0, d0, e0;

  initial begin
    rst = 1; in_valid = 0; in_sof = 0; in_data = '0;
    step(1, 0, 0, '0);
    step(1, 1, 1, 8'h55);
    step(0, 1, 0, 8'h77);
    step(0, 0, 0, '0);

    send_frame(0, 100, NPIX, 0, 0);
    send_frame(1, 100, NPIX, 17, 9);
    send_frame(1, 100, NPIX, 16, 8);
    send_frame(1, 70, NPIX, 31, 15);
    send_frame(2, 50, NPIX, 0, 0);
    send_frame(3, 50, NPIX, 0, 0);

    // Mid-frame resync: restart at accepted pixel 300.
    e0 = n_err; v0 = n_valid;
    send_frame(2, 100, 300, 0, 0);
    chk("no_zone_before_restart", 32'(n_valid - v0), 0);
    send_frame(3, 100, NPIX, 0, 0);
    chk("sof_err_count", 32'(n_err - e0), 1);

    // Reset on the last pixel of zone (3,0), then ignored pixels until in_sof.
    send_frame(3, 100, (ZONE_H - 1) * IMG_W + IMG_W - 1, 0, 0);
    v0 = n_valid;
    step(1, 1, 0, 8'hEE);
    for (int i = 0; i < 40; i++) step(0, 1, 0, DW'($urandom));
    chk("no_zone_after_rst", 32'(n_valid - v0), 0);
    send_frame(3, 80, NPIX, 0, 0);

    // Back-to-back frames.
    v0 = n_valid; d0 = n_done; e0 = n_err;
    send_frame(3, 100, NPIX, 0, 0);
    send_frame(2, 100, NPIX, 0, 0);
    chk("b2b_frame_done", 32'(n_done - d0), 2);
    chk("b2b_zone_count", 32'(n_valid - v0), 32'(2 * NZ));
    chk("b2b_sof_err", 32'(n_err - e0), 0);
    step(0, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
